// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for a common-anode multi-digit
//   7-segment display. One external combinational BCD-to-segment decoder is
//   shared by all digits. Each digit slot starts with a dark blanking phase
//   followed by a show phase. Display data is double-buffered (pending/active)
//   so that an update never tears in the middle of a frame.
//
// Parameters
//   NUM_DIGITS   : digits scanned (1..8)
//   CLK_DIV      : clock cycles per digit slot (>= 4)
//   BLANK_CYCLES : dark cycles at the start of each slot (1 .. CLK_DIV-2)
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   en         : scan enable; low forces the display dark
//   load       : one-cycle strobe capturing digits_in/dp_in/lz_en
//   digits_in  : BCD digits, digit 0 (rightmost) in bits [3:0]
//   dp_in      : decimal point per digit, 1 = lit
//   lz_en      : leading-zero suppression enable
//   bin_out    : value presented to the external decoder (15 = blank)
//   seg_in     : decoder result, active-low {a,b,c,d,e,f,g,dp}
//   seg_out    : registered segment drive, active-low, bit 0 = dp
//   com_n      : registered digit commons, active-low, one-cold or all ones
//   frame_done : one-cycle pulse after the last digit's slot ends
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [3:0]              bin_out,
  input  logic [7:0]              seg_in,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   com_n,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           frame_end;

  logic [NUM_DIGITS-1:0][3:0]     pend_digits, act_digits;
  logic [NUM_DIGITS-1:0]          pend_dp, act_dp;
  logic                           pend_lz, act_lz;
  logic                           copy_act;

  logic [NUM_DIGITS-1:0]          sup;
  logic                           zero_run;
  logic                           show;

  // ---------------------------------------------------------------- scan FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    frame_end = 1'b0;
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = BLANK;
            if (idx_q == IDX_LAST) begin
              idx_d     = '0;
              frame_end = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------- display buffers
  // The active copy is refreshed during the frame_done cycle (the first
  // BLANK cycle of a frame, where the digit data is not yet used) and on
  // every IDLE cycle. A load in the copy cycle bypasses pending so it lands
  // in the frame that is just starting.
  assign copy_act = (state_q == IDLE) || frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_lz     <= 1'b0;
      act_digits  <= '0;
      act_dp      <= '0;
      act_lz      <= 1'b0;
    end else begin
      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
        pend_lz     <= lz_en;
      end
      if (copy_act) begin
        act_digits <= load ? digits_in : pend_digits;
        act_dp     <= load ? dp_in     : pend_dp;
        act_lz     <= load ? lz_en     : pend_lz;
      end
    end
  end

  // ------------------------------------------------ decoder request (comb.)
  // A digit is suppressed when it and every digit above it are zero; the
  // scan runs from the top digit down so a single running flag suffices.
  always_comb begin
    sup      = '0;
    zero_run = act_lz;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (act_digits[k] == 4'd0);
      if (k != 0) sup[k] = zero_run;
    end
  end

  assign bin_out = ((state_q == SHOW) && !sup[idx_q]) ? act_digits[idx_q] : 4'd15;

  // ---------------------------------------------------------- output register
  assign show = (state_q == SHOW) && en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= 8'hFF;
      com_n      <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (show) begin
        seg_out <= {seg_in[7:1], seg_in[0] & ~act_dp[idx_q]};
        com_n   <= ~(NUM_DIGITS'(1) << idx_q);
      end else begin
        seg_out <= 8'hFF;
        com_n   <= '1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
  localparam int N  = 4;
  localparam int CD = 8;
  localparam int B  = 2;
  localparam int F  = N * CD;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           en = 1'b0;
  logic           load = 1'b0;
  logic           lz_en = 1'b0;
  logic [4*N-1:0] digits_in = '0;
  logic [N-1:0]   dp_in = '0;
  logic [3:0]     bin_out;
  logic [7:0]     seg_in;
  logic [7:0]     seg_out;
  logic [N-1:0]   com_n;
  logic           frame_done;

  int total = 0;
  int bad   = 0;

  seg_scan_ctrl #(.NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .lz_en(lz_en), .bin_out(bin_out), .seg_in(seg_in),
    .seg_out(seg_out), .com_n(com_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // External decoder, active-low {a,b,c,d,e,f,g,dp}
  function automatic logic [7:0] dec(input logic [3:0] v);
    case (v)
      4'd0: dec = 8'h03;  4'd1: dec = 8'h9F;  4'd2: dec = 8'h25;  4'd3: dec = 8'h0D;
      4'd4: dec = 8'h99;  4'd5: dec = 8'h49;  4'd6: dec = 8'h41;  4'd7: dec = 8'h1F;
      4'd8: dec = 8'h01;  4'd9: dec = 8'h09;  4'd10: dec = 8'hFD; 4'd11: dec = 8'hC1;
      4'd12: dec = 8'h63; 4'd13: dec = 8'h85; 4'd14: dec = 8'h61; default: dec = 8'hFF;
    endcase
  endfunction

  assign seg_in = dec(bin_out);

  // Reference: digit k is blank when lz is set, k>0 and the number formed
  // by digit k and above is zero.
  function automatic logic [3:0] bin_for(input int k, input logic [15:0] d, input logic lz);
    logic [15:0] upper;
    upper = d >> (4 * k);
    return (lz && k > 0 && upper == 16'd0) ? 4'd15 : upper[3:0];
  endfunction

  function automatic logic [7:0] seg_for(input int k, input logic [15:0] d,
                                         input logic [3:0] dp, input logic lz);
    logic [7:0] s;
    s = dec(bin_for(k, d, lz));
    if (dp[k]) s[0] = 1'b0;
    return s;
  endfunction

  // Behavioural model: m_t counts cycles since the scan started; slot and
  // phase follow from plain division. Frame data is a snapshot of the most
  // recent load, taken when scanning starts and at each frame_done cycle.
  bit          m_scan = 1'b0;
  int          m_t = 0;
  logic [15:0] lat_d = '0, frm_d = '0;
  logic [3:0]  lat_dp = '0, frm_dp = '0;
  logic        lat_lz = 1'b0, frm_lz = 1'b0;
  logic [7:0]  exp_seg = 8'hFF;
  logic [3:0]  exp_com = 4'hF;
  logic [3:0]  exp_bin = 4'hF;
  logic        exp_fd = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int          tn, slot;
    bit          sn, lit;
    logic [15:0] ld, fdg;
    logic [3:0]  ldp, fdp;
    logic        llz, flz;
    if (!rst_n) begin
      m_scan <= 1'b0; m_t <= 0;
      lat_d <= '0; lat_dp <= '0; lat_lz <= 1'b0;
      frm_d <= '0; frm_dp <= '0; frm_lz <= 1'b0;
      exp_seg <= 8'hFF; exp_com <= 4'hF; exp_bin <= 4'hF; exp_fd <= 1'b0;
    end else begin
      ld = lat_d; ldp = lat_dp; llz = lat_lz;
      if (load) begin ld = digits_in; ldp = dp_in; llz = lz_en; end
      fdg = frm_d; fdp = frm_dp; flz = frm_lz;
      lit  = m_scan && en && ((m_t % CD) >= B);
      slot = (m_t / CD) % N;
      exp_seg <= lit ? seg_for(slot, fdg, fdp, flz) : 8'hFF;
      exp_com <= lit ? ~(4'b0001 << slot) : 4'hF;
      exp_fd  <= m_scan && en && (((m_t + 1) % F) == 0);
      if (!en) begin
        sn = 1'b0; tn = 0; fdg = ld; fdp = ldp; flz = llz;
      end else if (!m_scan) begin
        sn = 1'b1; tn = 0; fdg = ld; fdp = ldp; flz = llz;
      end else begin
        if (m_t > 0 && (m_t % F) == 0) begin fdg = ld; fdp = ldp; flz = llz; end
        sn = 1'b1; tn = m_t + 1;
      end
      exp_bin <= (sn && (tn % CD) >= B) ? bin_for((tn / CD) % N, fdg, flz) : 4'd15;
      m_scan <= sn; m_t <= tn;
      lat_d <= ld; lat_dp <= ldp; lat_lz <= llz;
      frm_d <= fdg; frm_dp <= fdp; frm_lz <= flz;
    end
  end

  wire [16:0] obs  = {seg_out, com_n, bin_out, frame_done};
  wire [16:0] expv = {exp_seg, exp_com, exp_bin, exp_fd};

  task automatic drive_load(input logic [15:0] d, input logic [3:0] dp, input logic lz);
    digits_in = d; dp_in = dp; lz_en = lz; load = 1'b1;
  endtask

  task automatic test_reset;
    logic [16:0] rv;
    rv = {8'hFF, 4'hF, 4'hF, 1'b0};
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== rv) begin bad++; $display("FAIL reset_now obs=%h exp=%h", obs, rv); end
    repeat (3) @(negedge clk);
    total++;
    if (obs !== rv) begin bad++; $display("FAIL reset_hold obs=%h exp=%h", obs, rv); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lit_cnt[N];
    int fd_cnt;
    logic [3:0] seq[$];
    logic [3:0] exp_seq[4];
    exp_seq = '{4'd4, 4'd3, 4'd2, 4'd1};
    en = 1'b0;
    drive_load(16'h1234, 4'b0000, 1'b0);
    @(negedge clk); load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3 * F; i++) begin
      @(negedge clk); total++;
      if (obs !== expv) begin bad++; $display("FAIL basic_wait obs=%h exp=%h", obs, expv); end
      if (frame_done) break;
    end
    total++;
    if (frame_done !== 1'b1) begin bad++; $display("FAIL basic_fd_timeout fd=%b exp=1", frame_done); end
    fd_cnt = 0;
    foreach (lit_cnt[k]) lit_cnt[k] = 0;
    for (int i = 0; i < 2 * F; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL basic_scan obs=%h exp=%h", obs, expv); end
      if (frame_done) fd_cnt++;
      for (int k = 0; k < N; k++) if (com_n[k] == 1'b0) lit_cnt[k]++;
      if (bin_out != 4'd15 && (seq.size() == 0 || seq[$] != bin_out || i % CD == B)) seq.push_back(bin_out);
    end
    for (int k = 0; k < N; k++) begin
      total++;
      if (lit_cnt[k] != 12) begin bad++; $display("FAIL basic_lit%0d got=%0d exp=12", k, lit_cnt[k]); end
    end
    total++;
    if (fd_cnt != 2) begin bad++; $display("FAIL basic_fd_count got=%0d exp=2", fd_cnt); end
    total++;
    if (seq.size() != 8) begin bad++; $display("FAIL basic_seq_len got=%0d exp=8", seq.size()); end
    else for (int i = 0; i < 8; i++) begin
      total++;
      if (seq[i] !== exp_seq[i % 4]) begin bad++; $display("FAIL basic_seq%0d got=%0d exp=%0d", i, seq[i], exp_seq[i % 4]); end
    end
  endtask

  // Wait for frame_done, then check the following F-1 cycles (all showing
  // the new frame) against per-digit constant expectations.
  task automatic test_lz;
    logic [7:0] want[N];
    want = '{8'h02, 8'h1F, 8'hFF, 8'hFF};
    @(negedge clk); load = 1'b0; drive_load(16'h0070, 4'b0001, 1'b1);
    for (int i = 0; i < 3 * F; i++) begin
      @(negedge clk); load = 1'b0; total++;
      if (obs !== expv) begin bad++; $display("FAIL lz_wait obs=%h exp=%h", obs, expv); end
      if (frame_done) break;
    end
    total++;
    if (frame_done !== 1'b1) begin bad++; $display("FAIL lz_fd_timeout fd=%b exp=1", frame_done); end
    for (int i = 1; i < F; i++) begin
      @(negedge clk); total++;
      if (obs !== expv) begin bad++; $display("FAIL lz_scan obs=%h exp=%h", obs, expv); end
      for (int k = 0; k < N; k++) if (com_n == ~(4'b0001 << k)) begin
        total++;
        if (seg_out !== want[k]) begin bad++; $display("FAIL lz_digit%0d seg=%h exp=%h", k, seg_out, want[k]); end
      end
    end
  endtask

  task automatic test_midframe;
    int phase;
    bit seen9;
    @(negedge clk); drive_load(16'h1234, 4'b0000, 1'b0);
    for (int i = 0; i < 3 * F; i++) begin
      @(negedge clk); load = 1'b0; total++;
      if (obs !== expv) begin bad++; $display("FAIL mid_wait obs=%h exp=%h", obs, expv); end
      if (frame_done) break;
    end
    phase = 0; seen9 = 1'b0;
    for (int i = 0; i < 3 * F && !seen9; i++) begin
      @(negedge clk); load = 1'b0; total++;
      if (obs !== expv) begin bad++; $display("FAIL mid_scan obs=%h exp=%h", obs, expv); end
      if (phase == 0 && com_n == 4'b1101) begin
        drive_load(16'h9999, 4'b0000, 1'b0);
        phase = 1;
      end else if (phase == 1) begin
        if (com_n == 4'b1101 || com_n == 4'b1011 || com_n == 4'b0111) begin
          total++;
          if (seg_out !== (com_n == 4'b1101 ? 8'h0D : com_n == 4'b1011 ? 8'h25 : 8'h9F)) begin
            bad++; $display("FAIL mid_old com=%b seg=%h", com_n, seg_out);
          end
        end
        if (frame_done) phase = 2;
      end else if (phase == 2 && com_n == 4'b1110) begin
        total++;
        if (seg_out !== 8'h09) begin bad++; $display("FAIL mid_new seg=%h exp=09", seg_out); end
        seen9 = 1'b1;
      end
    end
    total++;
    if (!seen9) begin bad++; $display("FAIL mid_timeout phase=%0d exp=2", phase); end
  endtask

  task automatic test_en_drop;
    bit dropped;
    dropped = 1'b0;
    for (int i = 0; i < 3 * F; i++) begin
      @(negedge clk); load = 1'b0; total++;
      if (obs !== expv) begin bad++; $display("FAIL drop_wait obs=%h exp=%h", obs, expv); end
      if (com_n == 4'b1011) begin dropped = 1'b1; break; end
    end
    total++;
    if (!dropped) begin bad++; $display("FAIL drop_timeout com=%b exp=1011", com_n); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); total++;
      if ({seg_out, com_n, bin_out} !== {8'hFF, 4'hF, 4'hF}) begin
        bad++; $display("FAIL drop_dark seg=%h com=%b bin=%h exp=ff/1111/f", seg_out, com_n, bin_out);
      end
    end
    en = 1'b1;
    for (int i = 0; i <= B + 1; i++) begin
      @(negedge clk); total++;
      if (obs !== expv) begin bad++; $display("FAIL drop_restart obs=%h exp=%h", obs, expv); end
      total++;
      if (com_n !== (i <= B ? 4'hF : 4'b1110)) begin
        bad++; $display("FAIL drop_com%0d com=%b exp=%b", i, com_n, (i <= B ? 4'hF : 4'b1110));
      end
    end
  endtask

  task automatic test_async_reset;
    logic [16:0] rv;
    rv = {8'hFF, 4'hF, 4'hF, 1'b0};
    for (int i = 0; i < 2 * F; i++) begin
      @(negedge clk); total++;
      if (obs !== expv) begin bad++; $display("FAIL areset_wait obs=%h exp=%h", obs, expv); end
      if (com_n != 4'hF && bin_out != 4'hF) break;
    end
    @(posedge clk); #2 rst_n = 1'b0;
    #1 total++;
    if (obs !== rv) begin bad++; $display("FAIL areset_now obs=%h exp=%h", obs, rv); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 2 * F; i++) begin
      @(negedge clk); total++;
      if (obs !== expv) begin bad++; $display("FAIL areset_scan obs=%h exp=%h", obs, expv); end
      if (com_n != 4'hF) begin
        total++;
        if (seg_out !== 8'h03) begin bad++; $display("FAIL areset_zero seg=%h exp=03", seg_out); end
      end
    end
  endtask

  task automatic test_dash;
    logic [7:0] want[N];
    logic [7:0] want2[N];
    want  = '{8'h03, 8'hFD, 8'h03, 8'hFD};
    want2 = '{8'h9F, 8'h25, 8'h0D, 8'h99};
    drive_load(16'hA0A0, 4'b0000, 1'b1);
    for (int i = 0; i < 3 * F; i++) begin
      @(negedge clk); load = 1'b0; total++;
      if (obs !== expv) begin bad++; $display("FAIL dash_wait obs=%h exp=%h", obs, expv); end
      if (frame_done) break;
    end
    for (int i = 1; i < F; i++) begin
      @(negedge clk); total++;
      if (obs !== expv) begin bad++; $display("FAIL dash_scan obs=%h exp=%h", obs, expv); end
      for (int k = 0; k < N; k++) if (com_n == ~(4'b0001 << k)) begin
        total++;
        if (seg_out !== want[k]) begin bad++; $display("FAIL dash_digit%0d seg=%h exp=%h", k, seg_out, want[k]); end
      end
    end
    for (int i = 0; i < 2 * F; i++) begin
      @(negedge clk); total++;
      if (obs !== expv) begin bad++; $display("FAIL coinc_wait obs=%h exp=%h", obs, expv); end
      if (frame_done) break;
    end
    total++;
    if (frame_done !== 1'b1) begin bad++; $display("FAIL coinc_fd_timeout fd=%b exp=1", frame_done); end
    drive_load(16'h4321, 4'b0000, 1'b0);
    for (int i = 1; i < F; i++) begin
      @(negedge clk); load = 1'b0; total++;
      if (obs !== expv) begin bad++; $display("FAIL coinc_scan obs=%h exp=%h", obs, expv); end
      for (int k = 0; k < N; k++) if (com_n == ~(4'b0001 << k)) begin
        total++;
        if (seg_out !== want2[k]) begin bad++; $display("FAIL coinc_digit%0d seg=%h exp=%h", k, seg_out, want2[k]); end
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] d;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk); load = 1'b0; total++;
      if (obs !== expv) begin bad++; $display("FAIL rand cyc=%0d obs=%h exp=%h", i, obs, expv); end
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < N; k++) d[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 14));
        drive_load(d, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      if (en && $urandom_range(0, 59) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 2) == 0) en = 1'b1;
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_midframe();
    test_en_drop();
    test_async_reset();
    test_dash();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
